// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Purpose: bundles every channel of alu_share_arbiter except clk/rst.
//   request  : req_valid/req_ready (per requester) with packed req_a,
//              req_b, req_sel, req_cin payloads (requester i in slice i)
//   ALU bus  : registered operands alu_a/alu_b/alu_sel/alu_cin/alu_bin out,
//              combinational results alu_out1/alu_out2/alu_cout back
//   response : rsp_valid/rsp_ready with rsp_id, rsp_out1, rsp_out2,
//              rsp_cout, rsp_err
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters, ALU, response consumer)
interface alu_share_arbiter_if #(
    parameter int W = 8
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [7:0]     req_sel;
    logic [1:0]     req_cin;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_sel;
    logic           alu_cin;
    logic           alu_bin;
    logic [W-1:0]   alu_out1;
    logic [W-1:0]   alu_out2;
    logic           alu_cout;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_out1;
    logic [W-1:0]   rsp_out2;
    logic           rsp_cout;
    logic           rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_cin,
        output req_ready,
        output alu_a, alu_b, alu_sel, alu_cin, alu_bin,
        input  alu_out1, alu_out2, alu_cout,
        output rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_cout, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, req_cin,
        input  req_ready,
        input  alu_a, alu_b, alu_sel, alu_cin, alu_bin,
        output alu_out1, alu_out2, alu_cout,
        input  rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_cout, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Purpose: shares one combinational 8-bit ALU between two requesters.
//   Round-robin grant in IDLE, operands registered toward the ALU, one
//   settle cycle (EXEC), then the masked ALU result is registered and
//   offered on a valid/ready response channel tagged with the requester ID.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          alu_share_arbiter_if.slave (request, ALU and response channels)
//   stat_grant0  grants to requester 0        (ALU_ARB_STATS_EN only)
//   stat_grant1  grants to requester 1        (ALU_ARB_STATS_EN only)
//   stat_err     illegal-opcode responses     (ALU_ARB_STATS_EN only)
// Build option:
//   ALU_ARB_STATS_EN - adds the three saturating 16-bit statistics counters.
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        stat_grant0,
    output logic [15:0]        stat_grant1,
    output logic [15:0]        stat_err
`endif
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [ID_W-1:0] r_rr;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_gnt_any;
    logic [1:0]      w_req_ready;
    logic            w_accept;
    logic            w_rsp_valid;

    logic [W-1:0]    w_gnt_a;
    logic [W-1:0]    w_gnt_b;
    logic [3:0]      w_gnt_sel;
    logic            w_gnt_cin;

    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [3:0]      r_alu_sel;
    logic            r_alu_cin;
    logic            r_alu_bin;

    logic [W-1:0]    r_rsp_out1;
    logic [W-1:0]    r_rsp_out2;
    logic            r_rsp_cout;
    logic            r_rsp_err;
    logic [2*W+1:0]  w_masked;

    // Keep only the ALU outputs that are meaningful for the opcode; the rest
    // of the ALU bus may carry stale or undefined values.
    function automatic logic [2*W+1:0] mask_result(
        input logic [3:0]   sel,
        input logic [W-1:0] out1,
        input logic [W-1:0] out2,
        input logic         cout
    );
        logic [W-1:0] m1;
        logic [W-1:0] m2;
        logic         mc;
        logic         me;
        m1 = '0;
        m2 = '0;
        mc = 1'b0;
        me = 1'b0;
        case (sel)
            4'd0, 4'd1: begin m1 = out1; mc = cout; end
            4'd2, 4'd5: begin m1 = out1; m2 = out2; end
            4'd3, 4'd4: m1 = out1;
            default:    me = 1'b1;
        endcase
        return {m1, m2, mc, me};
    endfunction

    // Arbitration: a lone requester wins outright; on contention rr_ptr decides.
    always_comb begin
        w_gnt_any = |bus.req_valid;
        w_gnt_id  = r_rr;
        if (bus.req_valid == 2'b01) begin
            w_gnt_id = '0;
        end else if (bus.req_valid == 2'b10) begin
            w_gnt_id = 1'b1;
        end
    end

    assign w_gnt_a   = bus.req_a[int'(w_gnt_id)*W +: W];
    assign w_gnt_b   = bus.req_b[int'(w_gnt_id)*W +: W];
    assign w_gnt_sel = bus.req_sel[int'(w_gnt_id)*4 +: 4];
    assign w_gnt_cin = bus.req_cin[w_gnt_id];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_req_ready = '0;
        w_rsp_valid = (r_state == RESP);
        if (r_state == IDLE && w_gnt_any) begin
            w_req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_accept  = |(bus.req_valid & w_req_ready);
    assign w_masked  = mask_result(r_alu_sel, bus.alu_out1, bus.alu_out2, bus.alu_cout);

    // Operand capture on accept, response capture at the end of EXEC.
    // Neither is touched otherwise, so the ALU inputs and the response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr       <= '0;
            r_id       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_alu_cin  <= 1'b0;
            r_alu_bin  <= 1'b0;
            r_rsp_out1 <= '0;
            r_rsp_out2 <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_gnt_a;
                r_alu_b   <= w_gnt_b;
                r_alu_sel <= w_gnt_sel;
                // req_cin doubles as borrow-in; route it only to the port the
                // opcode actually uses.
                r_alu_cin <= (w_gnt_sel == 4'd0) ? w_gnt_cin : 1'b0;
                r_alu_bin <= (w_gnt_sel == 4'd1) ? w_gnt_cin : 1'b0;
                r_id      <= w_gnt_id;
                r_rr      <= ~w_gnt_id;
            end
            if (r_state == EXEC) begin
                {r_rsp_out1, r_rsp_out2, r_rsp_cout, r_rsp_err} <= w_masked;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.alu_cin   = r_alu_cin;
    assign bus.alu_bin   = r_alu_bin;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_out1  = r_rsp_out1;
    assign bus.rsp_out2  = r_rsp_out2;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_err   = r_rsp_err;

`ifdef ALU_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [15:0] r_stat_g0;
    logic [15:0] r_stat_g1;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_g0  <= '0;
            r_stat_g1  <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_accept && w_gnt_id == '0) r_stat_g0 <= sat_inc(r_stat_g0);
            if (w_accept && w_gnt_id != '0) r_stat_g1 <= sat_inc(r_stat_g1);
            if (w_rsp_valid && bus.rsp_ready && r_rsp_err) r_stat_err <= sat_inc(r_stat_err);
        end
    end

    assign stat_grant0 = r_stat_g0;
    assign stat_grant1 = r_stat_g1;
    assign stat_err    = r_stat_err;
`endif
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU (`alu_8bit`: sel 0 add, 1 sub, 2 shift, 3 mul-by-4, 4 div-by-4, 5 complement) between two requesters.
- Arbitrates round-robin, registers the winning operands and drives the ALU from those registers.
- Captures the ALU results one cycle later and returns them on a valid/ready response channel tagged with the requester ID.
- Masks the ALU's undefined/latched outputs so every response is fully deterministic.

Parameters:
- N_REQ, 2, number of requesters; fixed at 2 in this revision, ID width 1.
- W, 8, operand/result width; must match ALU width.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept (one-hot or zero).
- req_a  in  2*W  operand A; requester i at [i*W +: W].
- req_b  in  2*W  operand B, packed the same way.
- req_sel  in  2*4  opcode; requester i at [i*4 +: 4].
- req_cin  in  2  carry-in for add, borrow-in for sub.
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_sel  out  4  registered opcode to the ALU.
- alu_cin, alu_bin  out  1  registered carry-in and borrow-in to the ALU.
- alu_out1, alu_out2  in  W  ALU results.
- alu_cout  in  1  ALU carry/borrow out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_out1, rsp_out2  out  W  result words.
- rsp_cout  out  1  carry/borrow.
- rsp_err  out  1  illegal opcode (sel > 5).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - State IDLE, rr_ptr=0.
  - alu_a, alu_b, alu_sel, alu_cin, alu_bin all 0.
  - rsp_valid=0; rsp_id, rsp_out1, rsp_out2, rsp_cout, rsp_err all 0.
  - req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant:
  - req_ready is combinational: only in IDLE, and only to the granted requester.
  - If both requesters are valid, requester rr_ptr wins. If one is valid, it wins regardless of rr_ptr.
- IDLE, accept edge (req_valid&req_ready):
  - Latch operands into alu_*.
  - alu_cin = req_cin when sel==0, else 0. alu_bin = req_cin when sel==1, else 0.
  - Latch the ID; rr_ptr := ~granted ID.
  - Go to EXEC.
- EXEC (exactly 1 cycle, ALU settle): at end of cycle, register the response and go to RESP.
  - sel 0,1: out1=alu_out1, out2=0, cout=alu_cout.
  - sel 2,5: out1=alu_out1, out2=alu_out2, cout=0.
  - sel 3,4: out1=alu_out1, out2=0, cout=0.
  - sel 6..15: out1=out2=0, cout=0, rsp_err=1.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
  - No new accept before the IDLE cycle. Minimum issue interval is 3 cycles; accept-to-rsp_valid latency is 2 cycles.
- alu_* registers hold their last value outside accept edges; they are not cleared on response.
- Requester obligations: a request once asserted holds its payload until accepted (requester's obligation). A valid deasserted in IDLE before grant is simply dropped.
- Reset mid-operation (EXEC or RESP): returns to IDLE next edge and drops the transaction silently; no response is produced.
- rsp_ready held high permanently gives back-to-back service with strict alternation under dual load.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds out ports stat_grant0 (16), stat_grant1 (16), stat_err (16).
  - Each counter increments on the corresponding accept or error-response handshake.
  - Counters saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Add, requester 0 alone: a=8'hF0, b=8'h20, sel=0, cin=1 -> accept on cycle N; rsp_valid at N+2; out1=8'h11, cout=1, out2=0, id=0, err=0.
- Subtract, requester 1 alone: a=8'h05, b=8'h07, sel=1, cin=0 -> out1=8'hFE, cout=1 (borrow), id=1, alu_cin=0, alu_bin=0.
- Both valid continuously, rsp_ready=1:
  - Both sel=2, a0=8'h81, a1=8'h3C.
  - Grants alternate 0,1,0,1.
  - id=0 response: out1=8'h04, out2=8'h20.
  - id=1 response: out1=8'hF0, out2=8'h0F.
  - Accepts spaced exactly 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, sel=5, a=8'hAA, b=8'h0F -> rsp fields stable (out1=8'h55, out2=8'hF0). req_ready=0 throughout; completes on the first rsp_ready=1 cycle.
- Illegal opcode sel=4'hB on requester 0, after a prior sel=2 response -> out1=out2=0, cout=0, err=1. Then a sel=3 request with a=8'h13 gives out1=8'h4C, out2=0 (no stale out2).
- rst asserted during RESP -> next cycle rsp_valid=0, state IDLE, rr_ptr=0. With ALU_ARB_STATS_EN: counters read 0, and a subsequent single grant0 makes stat_grant0=1.
